// File: rtl/lin_reg_dev.sv
// lin_reg_dev: two-pass window statistics engine.
// Scans caller memory over [si, ei) to produce the integer mean, then the mean
// absolute deviation about that mean. Each pass is followed by a serial
// restoring division by the window length N.
module lin_reg_dev #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] si,
    input  logic [WIDTH-1:0] ei,
    input  logic             start,
    output logic [WIDTH-1:0] index,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] mean,
    output logic [WIDTH-1:0] deviation,
    output logic             done
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(ACC_W);
    localparam logic [WIDTH-1:0] ONE      = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPass1,
        StDiv1,
        StPass2,
        StDiv2,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_si;
    logic [WIDTH-1:0] r_ei;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_index;
    logic [ACC_W-1:0] r_acc;      // pass accumulator, then dividend/quotient shift register
    logic [WIDTH:0]   r_rem;      // partial remainder, always < N
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mean;
    logic [WIDTH-1:0] r_dev;
    logic             r_done;

    logic             w_idle;
    logic             w_empty;
    logic             w_scan_last;
    logic             w_div_last;
    logic [WIDTH-1:0] w_absdiff;
    logic [WIDTH+1:0] w_rem_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_next;
    logic [ACC_W-1:0] w_acc_shift;

    assign w_idle      = (r_state == StIdle) || (r_state == StDone);
    assign w_empty     = (ei <= si);
    assign w_scan_last = (r_index == (r_ei - ONE));
    assign w_div_last  = (r_cnt == CNT_LAST);

    // Non-wrapping |value - mean|: larger minus smaller.
    assign w_absdiff = (value >= r_mean) ? (value - r_mean) : (r_mean - value);

    // One restoring-division step: shift in the next dividend bit, subtract N if it fits.
    assign w_rem_shift = {r_rem, r_acc[ACC_W-1]};
    assign w_ge        = (w_rem_shift >= {2'b00, r_n});
    assign w_rem_next  = w_ge ? (WIDTH+1)'(w_rem_shift - {2'b00, r_n}) : w_rem_shift[WIDTH:0];
    assign w_acc_shift = {r_acc[ACC_W-2:0], w_ge};

    // State register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_next = w_empty ? StDone : StPass1;
                end
            end
            StPass1: if (w_scan_last) w_state_next = StDiv1;
            StDiv1:  if (w_div_last)  w_state_next = StPass2;
            StPass2: if (w_scan_last) w_state_next = StDiv2;
            StDiv2:  if (w_div_last)  w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: window latch, scan accumulation, serial division and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_si    <= '0;
            r_ei    <= '0;
            r_n     <= '0;
            r_index <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_mean  <= '0;
            r_dev   <= '0;
            r_done  <= 1'b0;
        end else if (w_idle) begin
            if (start) begin
                r_si    <= si;
                r_ei    <= ei;
                r_n     <= ei - si;
                r_index <= si;
                r_acc   <= '0;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_done  <= 1'b0;
                if (w_empty) begin
                    r_mean <= '0;
                    r_dev  <= '0;
                    r_done <= 1'b1;
                end
            end
        end else begin
            case (r_state)
                StPass1: begin
                    r_acc   <= r_acc + {{WIDTH{1'b0}}, value};
                    r_index <= r_index + ONE;
                end
                StPass2: begin
                    r_acc   <= r_acc + {{WIDTH{1'b0}}, w_absdiff};
                    r_index <= r_index + ONE;
                end
                StDiv1, StDiv2: begin
                    r_acc <= w_acc_shift;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CNT_ONE;   // wraps to 0 on the last step
                    if (w_div_last) begin
                        r_rem <= '0;
                        if (r_state == StDiv1) begin
                            r_mean  <= w_acc_shift[WIDTH-1:0];
                            r_index <= r_si;
                            r_acc   <= '0;
                        end else begin
                            r_dev  <= w_acc_shift[WIDTH-1:0];
                            r_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign index     = r_index;
    assign mean      = r_mean;
    assign deviation = r_dev;
    assign done      = r_done;

endmodule

// File: tb/tb_lin_reg_dev.sv
// Bench for lin_reg_dev: directed scenarios plus randomized windows checked
// against a plain-arithmetic mean / mean-absolute-deviation model.
module tb_lin_reg_dev;

    localparam int W = 32;
    localparam int DIV_EDGES = 2 * W;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] si;
    logic [31:0] ei;
    logic        start;
    logic [31:0] index;
    logic [31:0] value;
    logic [31:0] mean;
    logic [31:0] deviation;
    logic        done;

    logic [31:0] mem [16];
    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    // Caller-owned array answers combinationally.
    assign value = (index < 32'd16) ? mem[index[3:0]] : 32'hDEAD_BEEF;

    lin_reg_dev #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .si        (si),
        .ei        (ei),
        .start     (start),
        .index     (index),
        .value     (value),
        .mean      (mean),
        .deviation (deviation),
        .done      (done)
    );

    // Reference: integer mean and mean absolute deviation of mem[s..e-1].
    function automatic void model(input int s, input int e,
                                  output logic [31:0] m, output logic [31:0] d);
        longint unsigned sum;
        longint unsigned n;
        m = 0;
        d = 0;
        if (e <= s) return;
        n = longint'(e - s);
        sum = 0;
        for (int i = s; i < e; i++) sum += mem[i];
        m = 32'(sum / n);
        sum = 0;
        for (int i = s; i < e; i++) sum += (mem[i] > m) ? (mem[i] - m) : (m - mem[i]);
        d = 32'(sum / n);
    endfunction

    function automatic int latency(input int s, input int e);
        return (e > s) ? 2 * (e - s) + 2 * DIV_EDGES : 0;
    endfunction

    task automatic load_nominal();
        int data [10] = '{33, 23, 15, 12, 82, 64, 53, 58, 66, 39};
        for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? 32'(data[i]) : 32'd0;
    endtask

    // Issue one start and wait for done; edges counts clock edges after the accepting edge.
    task automatic run(input int s, input int e, input bit busy, output int edges,
                       output int idx_err, output logic drop, output logic [31:0] early_mean);
        int n;
        int limit;
        int k;
        n = (e > s) ? e - s : 0;
        limit = latency(s, e) + 50;
        idx_err = 0;
        early_mean = 'x;
        @(negedge Clk);
        si = 32'(s);
        ei = 32'(e);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        drop = done;
        k = 0;
        while (!done && k < limit) begin
            if (k < n && index !== 32'(s + k)) idx_err++;
            if (k >= n + DIV_EDGES && k < 2 * n + DIV_EDGES &&
                index !== 32'(s + k - n - DIV_EDGES)) idx_err++;
            if (k == n + DIV_EDGES) early_mean = mean;
            if (busy && k == n + DIV_EDGES + 2) begin
                start = 1'b1;
                si = 32'd0;
                ei = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge Clk);
            k++;
        end
        start = 1'b0;
        edges = k;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        start = 1'b1;
        si = 32'd0;
        ei = 32'd10;
        repeat (2) @(negedge Clk);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset done: got %0b want 0", done); end
        n_checks++; if (mean !== 32'd0) begin n_errors++; $display("FAIL reset mean: got %0d want 0", mean); end
        n_checks++; if (deviation !== 32'd0) begin n_errors++; $display("FAIL reset deviation: got %0d want 0", deviation); end
        n_checks++; if (index !== 32'd0) begin n_errors++; $display("FAIL reset index: got %0d want 0", index); end
        Rst = 1'b0;
        start = 1'b0;
        repeat (5) @(negedge Clk);
        n_checks++; if (index !== 32'd0 || done !== 1'b0) begin
            n_errors++; $display("FAIL reset no_scan: got index=%0d done=%0b want 0/0", index, done);
        end
    endtask

    task automatic test_nominal();
        int edges, ierr;
        logic drop;
        logic [31:0] em;
        load_nominal();
        run(0, 10, 1'b0, edges, ierr, drop, em);
        n_checks++; if (edges != 148) begin n_errors++; $display("FAIL nominal latency: got %0d want 148", edges); end
        n_checks++; if (mean !== 32'd44) begin n_errors++; $display("FAIL nominal mean: got %0d want 44", mean); end
        n_checks++; if (deviation !== 32'd20) begin n_errors++; $display("FAIL nominal deviation: got %0d want 20", deviation); end
        n_checks++; if (ierr != 0) begin n_errors++; $display("FAIL nominal index_seq: got %0d bad steps want 0", ierr); end
        n_checks++; if (em !== 32'd44) begin n_errors++; $display("FAIL nominal early_mean: got %0d want 44", em); end
    endtask

    task automatic test_subwindow();
        int edges, ierr;
        logic drop;
        logic [31:0] em;
        run(4, 7, 1'b0, edges, ierr, drop, em);
        n_checks++; if (edges != 134) begin n_errors++; $display("FAIL sub latency: got %0d want 134", edges); end
        n_checks++; if (mean !== 32'd66) begin n_errors++; $display("FAIL sub mean: got %0d want 66", mean); end
        n_checks++; if (deviation !== 32'd10) begin n_errors++; $display("FAIL sub deviation: got %0d want 10", deviation); end
        n_checks++; if (ierr != 0) begin n_errors++; $display("FAIL sub index_seq: got %0d bad steps want 0", ierr); end
    endtask

    task automatic test_empty();
        int edges, ierr;
        logic drop;
        logic [31:0] em;
        int ss [2] = '{5, 7};
        int ee [2] = '{5, 3};
        for (int t = 0; t < 2; t++) begin
            run(ss[t], ee[t], 1'b0, edges, ierr, drop, em);
            n_checks++; if (edges != 0 || done !== 1'b1) begin
                n_errors++; $display("FAIL empty%0d done: got edges=%0d done=%0b want 0/1", t, edges, done);
            end
            n_checks++; if (mean !== 32'd0 || deviation !== 32'd0) begin
                n_errors++; $display("FAIL empty%0d result: got %0d/%0d want 0/0", t, mean, deviation);
            end
        end
    endtask

    task automatic test_busy();
        int edges, ierr;
        logic drop;
        logic [31:0] em;
        run(0, 10, 1'b1, edges, ierr, drop, em);
        n_checks++; if (edges != 148) begin n_errors++; $display("FAIL busy latency: got %0d want 148", edges); end
        n_checks++; if (mean !== 32'd44 || deviation !== 32'd20) begin
            n_errors++; $display("FAIL busy result: got %0d/%0d want 44/20", mean, deviation);
        end
    endtask

    task automatic test_restart();
        int edges, ierr;
        logic drop;
        logic [31:0] em;
        mem[0] = 32'd10;
        mem[1] = 32'd20;
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL restart pre_done: got %0b want 1", done); end
        run(0, 2, 1'b0, edges, ierr, drop, em);
        n_checks++; if (drop !== 1'b0) begin n_errors++; $display("FAIL restart done_drop: got %0b want 0", drop); end
        n_checks++; if (edges != 132) begin n_errors++; $display("FAIL restart latency: got %0d want 132", edges); end
        n_checks++; if (mean !== 32'd15 || deviation !== 32'd5) begin
            n_errors++; $display("FAIL restart result: got %0d/%0d want 15/5", mean, deviation);
        end
    endtask

    task automatic test_reset_mid();
        int edges, ierr;
        logic drop;
        logic [31:0] em;
        load_nominal();
        @(negedge Clk);
        si = 32'd0;
        ei = 32'd10;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (15) @(negedge Clk);     // now inside DIV1
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        n_checks++; if (index !== 32'd0 || done !== 1'b0) begin
            n_errors++; $display("FAIL midrst idx_done: got %0d/%0b want 0/0", index, done);
        end
        n_checks++; if (mean !== 32'd0 || deviation !== 32'd0) begin
            n_errors++; $display("FAIL midrst result: got %0d/%0d want 0/0", mean, deviation);
        end
        repeat (200) @(negedge Clk);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL midrst aborted: got done=%0b want 0", done); end
        run(0, 10, 1'b0, edges, ierr, drop, em);
        n_checks++; if (edges != 148 || mean !== 32'd44 || deviation !== 32'd20) begin
            n_errors++; $display("FAIL midrst rerun: got %0d edges %0d/%0d want 148 44/20", edges, mean, deviation);
        end
    endtask

    task automatic test_random();
        int edges, ierr, s, e;
        logic drop;
        logic [31:0] em, m, d;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = (it % 2 == 0) ? $urandom_range(0, 1000) : $urandom();
            s = $urandom_range(0, 15);
            e = (it == 3) ? s : $urandom_range(0, 16);
            model(s, e, m, d);
            run(s, e, 1'b0, edges, ierr, drop, em);
            n_checks++; if (edges != latency(s, e)) begin
                n_errors++; $display("FAIL rand%0d latency [%0d,%0d): got %0d want %0d", it, s, e, edges, latency(s, e));
            end
            n_checks++; if (mean !== m) begin
                n_errors++; $display("FAIL rand%0d mean [%0d,%0d): got %0d want %0d", it, s, e, mean, m);
            end
            n_checks++; if (deviation !== d) begin
                n_errors++; $display("FAIL rand%0d deviation [%0d,%0d): got %0d want %0d", it, s, e, deviation, d);
            end
            n_checks++; if (ierr != 0) begin
                n_errors++; $display("FAIL rand%0d index_seq: got %0d bad steps want 0", it, ierr);
            end
        end
    endtask

    initial begin
        Rst = 1'b1;
        start = 1'b0;
        si = '0;
        ei = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_nominal();
        test_subwindow();
        test_empty();
        test_busy();
        test_restart();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
